move_resolver: RTL and testbench
================================

MOVE_RESOLVER -- requirements
Module: move_resolver

Interface
REQ-001 Parameter MAP_W, default 16, playable columns; x in 0..MAP_W-1.
REQ-002 Parameter MAP_H, default 16, playable rows; y in 0..MAP_H-1.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 ask_move  input  1  move request, held high until accept_move is sampled.
REQ-006 ask_x, ask_y  input  4 each  requested target tile, stable while ask_move high.
REQ-007 cur_x, cur_y  input  4 each  requester's current position.
REQ-008 accept_move  output  1  one-cycle response pulse; every request gets exactly one.
REQ-009 goto_x, goto_y  output  4 each  resolved position, valid while accept_move high.
REQ-010 map_addr  output  8  tile address {y[3:0],x[3:0]}.
REQ-011 map_rdata  input  3  tile code; valid one cycle after map_addr is registered.
REQ-012 map_we  output  1  one-cycle write strobe.
REQ-013 map_wdata  output  3  tile code to write.
REQ-014 push_done  output  1  one-cycle pulse coincident with accept_move on a successful box push.
REQ-015 step_cnt  output  10  count of granted moves.

Function
REQ-016 Tile codes SHALL be: 0 floor, 1 wall, 2 goal, 3 box, 4 box-on-goal; codes 5-7 SHALL be treated as wall.
REQ-017 States SHALL be IDLE, WAIT_T, CHK_T, WAIT_B, CHK_B, WR_T, DONE.
REQ-018 IDLE with ask_move=0 SHALL hold all outputs at rest (accept_move=0, map_we=0, push_done=0).
REQ-019 IDLE with ask_move=1: dx=ask_x-cur_x, dy=ask_y-cur_y; the request is valid only if exactly one of dx, dy is ±1, the other is 0, and the target is in bounds. The resolver SHALL latch ask, cur, dx and dy.
REQ-020 Invalid request, decided at the IDLE edge: accept_move<=1, goto<=cur, go to DONE; no map access.
REQ-021 Valid request: map_addr<=target, go to WAIT_T; the next edge goes to CHK_T.
REQ-022 CHK_T, target floor or goal: grant, i.e. accept_move<=1, goto<=ask, step_cnt+=1, go to DONE.
REQ-023 CHK_T, target wall: deny, i.e. accept_move<=1, goto<=cur, go to DONE.
REQ-024 CHK_T, target box or box-on-goal: the beyond tile is target+(dx,dy). If it is out of bounds, deny. Otherwise map_addr<=beyond and go to WAIT_B, then CHK_B.
REQ-025 CHK_B, beyond tile is a box, box-on-goal or wall: deny, with no map write.
REQ-026 CHK_B, beyond tile floor or goal: map_we<=1, map_addr<=beyond, map_wdata<=(goal?4:3), go to WR_T.
REQ-027 WR_T: map_we<=1, map_addr<=target, map_wdata<=(target was 4 ? 2 : 0); accept_move<=1, goto<=ask, push_done<=1, step_cnt+=1, go to DONE.
REQ-028 Latency from the edge sampling ask_move: invalid, accept high after edge 0; floor, goal or wall, after edge 2; blocked push, after edge 4; successful push, after edge 5.
REQ-029 accept_move, push_done and map_we SHALL each be high for exactly one cycle.
REQ-030 DONE SHALL clear the pulses, and SHALL return to IDLE only on an edge sampling ask_move=0. A request held high SHALL never be resolved twice.
REQ-031 step_cnt SHALL saturate at 1023 without wrapping.
REQ-032 Bounds arithmetic SHALL use signed 5-bit values. x=15 plus 1, or 0 minus 1, SHALL be out of bounds, never wrapping.
REQ-033 ask_x and ask_y changing while a request is in flight SHALL be ignored; only the latched values are used.

Reset
REQ-034 rstn low SHALL immediately set: state IDLE, accept_move=0, goto=0, map_addr=0, map_we=0, map_wdata=0, push_done=0, step_cnt=0.
REQ-035 Reset during WR_T may leave a duplicated box in the map. The level loader reloads the map after any reset, so no recovery logic is required.

Verification
REQ-036 cur=(6,11), ask=(7,11), tile{11,7}=0 -> accept after edge 2, goto=(7,11), step_cnt=1, map_we never high.
REQ-037 Same request with tile{11,7}=1 -> goto=(6,11), step_cnt unchanged.
REQ-038 tile{11,7}=3, tile{11,8}=2 -> writes {11,8}<=4 then {11,7}<=0, accept and push_done after edge 5, goto=(7,11).
REQ-039 tile{11,7}=3, tile{11,8}=3 -> deny after edge 4, goto=(6,11), no write. cur=(15,3), ask=(0,3) -> invalid, immediate deny.
REQ-040 ask_move held high for 10 cycles after accept -> exactly one accept pulse. rstn pulsed low in WAIT_B -> all outputs 0 at once, IDLE after release.

Source files
------------

// File: rtl/move_resolver.sv
// Tile-map move resolver: checks a one-step move, pushes a box when
// possible, and answers every request with a single accept pulse.
module move_resolver #(
  parameter int MAP_W = 16,
  parameter int MAP_H = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ask_move,
  input  logic [3:0] ask_x,
  input  logic [3:0] ask_y,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  output logic       accept_move,
  output logic [3:0] goto_x,
  output logic [3:0] goto_y,
  output logic [7:0] map_addr,
  input  logic [2:0] map_rdata,
  output logic       map_we,
  output logic [2:0] map_wdata,
  output logic       push_done,
  output logic [9:0] step_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WT   = 3'd1;
  localparam logic [2:0] S_CT   = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_CB   = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [4:0] W5 = 5'(MAP_W);
  localparam logic [4:0] H5 = 5'(MAP_H);

  logic [2:0] state_q, state_d;
  logic       acc_q, acc_d;
  logic [3:0] gx_q, gx_d, gy_q, gy_d;
  logic [7:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [2:0] wd_q, wd_d;
  logic       push_q, push_d;
  logic [9:0] cnt_q, cnt_d;
  logic [3:0] ax_q, ax_d, ay_q, ay_d;
  logic [3:0] cx_q, cx_d, cy_q, cy_d;
  logic signed [4:0] dx_q, dx_d, dy_q, dy_d;
  logic       tgoal_q, tgoal_d;

  logic signed [4:0] dx_c, dy_c, bx_c, by_c;
  logic       unit_c, tin_c, bin_c;
  logic [9:0] cnt_inc;

  assign dx_c = $signed({1'b0, ask_x}) - $signed({1'b0, cur_x});
  assign dy_c = $signed({1'b0, ask_y}) - $signed({1'b0, cur_y});

  assign unit_c =
    ((dx_c == 5'sd1 || dx_c == -5'sd1) && dy_c == 5'sd0) ||
    ((dy_c == 5'sd1 || dy_c == -5'sd1) && dx_c == 5'sd0);
  assign tin_c = ({1'b0, ask_x} < W5) && ({1'b0, ask_y} < H5);

  // 15+1 lands on 5'b10000, so the sign bit flags both edges
  assign bx_c = $signed({1'b0, ax_q}) + dx_q;
  assign by_c = $signed({1'b0, ay_q}) + dy_q;
  assign bin_c = !bx_c[4] && !by_c[4] &&
    ({1'b0, bx_c[3:0]} < W5) && ({1'b0, by_c[3:0]} < H5);

  assign cnt_inc = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;

  always_comb begin
    state_d = state_q;
    acc_d   = 1'b0;
    we_d    = 1'b0;
    push_d  = 1'b0;
    gx_d    = gx_q;
    gy_d    = gy_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    tgoal_d = tgoal_q;
    unique case (state_q)
      S_IDLE: begin
        if (ask_move) begin
          ax_d = ask_x;
          ay_d = ask_y;
          cx_d = cur_x;
          cy_d = cur_y;
          dx_d = dx_c;
          dy_d = dy_c;
          if (unit_c && tin_c) begin
            addr_d  = {ask_y, ask_x};
            state_d = S_WT;
          end else begin
            acc_d   = 1'b1;
            gx_d    = cur_x;
            gy_d    = cur_y;
            state_d = S_DONE;
          end
        end
      end
      S_WT: state_d = S_CT;
      S_CT: begin
        tgoal_d = (map_rdata == 3'd4);
        unique case (1'b1)
          (map_rdata == 3'd0 || map_rdata == 3'd2): begin
            acc_d   = 1'b1;
            gx_d    = ax_q;
            gy_d    = ay_q;
            cnt_d   = cnt_inc;
            state_d = S_DONE;
          end
          (map_rdata == 3'd3 || map_rdata == 3'd4) && bin_c: begin
            addr_d  = {by_c[3:0], bx_c[3:0]};
            state_d = S_WB;
          end
          default: begin
            acc_d   = 1'b1;
            gx_d    = cx_q;
            gy_d    = cy_q;
            state_d = S_DONE;
          end
        endcase
      end
      S_WB: state_d = S_CB;
      S_CB: begin
        if (map_rdata == 3'd0 || map_rdata == 3'd2) begin
          we_d    = 1'b1;
          wd_d    = (map_rdata == 3'd2) ? 3'd4 : 3'd3;
          state_d = S_WR;
        end else begin
          acc_d   = 1'b1;
          gx_d    = cx_q;
          gy_d    = cy_q;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        we_d    = 1'b1;
        addr_d  = {ay_q, ax_q};
        wd_d    = tgoal_q ? 3'd2 : 3'd0;
        acc_d   = 1'b1;
        push_d  = 1'b1;
        gx_d    = ax_q;
        gy_d    = ay_q;
        cnt_d   = cnt_inc;
        state_d = S_DONE;
      end
      S_DONE: if (!ask_move) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      acc_q   <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      push_q  <= 1'b0;
      cnt_q   <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      tgoal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      push_q  <= push_d;
      cnt_q   <= cnt_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      tgoal_q <= tgoal_d;
    end
  end

  assign accept_move = acc_q;
  assign goto_x      = gx_q;
  assign goto_y      = gy_q;
  assign map_addr    = addr_q;
  assign map_we      = we_q;
  assign map_wdata   = wd_q;
  assign push_done   = push_q;
  assign step_cnt    = cnt_q;

endmodule

// File: tb/tb_move_resolver.sv
// Directed bench for move_resolver with a behavioural tile RAM
// (registered read, write on strobe).
module tb_move_resolver;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ask_move = 1'b0;
  logic [3:0] ask_x = '0, ask_y = '0;
  logic [3:0] cur_x = '0, cur_y = '0;
  logic       accept_move;
  logic [3:0] goto_x, goto_y;
  logic [7:0] map_addr;
  logic [2:0] map_rdata = '0;
  logic       map_we;
  logic [2:0] map_wdata;
  logic       push_done;
  logic [9:0] step_cnt;

  logic [2:0] mem [256];

  int n_vec = 0;
  int n_bad = 0;

  move_resolver dut (
    .clk(clk), .rstn(rstn),
    .ask_move(ask_move),
    .ask_x(ask_x), .ask_y(ask_y),
    .cur_x(cur_x), .cur_y(cur_y),
    .accept_move(accept_move),
    .goto_x(goto_x), .goto_y(goto_y),
    .map_addr(map_addr), .map_rdata(map_rdata),
    .map_we(map_we), .map_wdata(map_wdata),
    .push_done(push_done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    map_rdata <= mem[map_addr];
    if (map_we) mem[map_addr] <= map_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_tile(input logic [3:0] x, input logic [3:0] y,
                          input logic [2:0] c);
    mem[{y, x}] = c;
  endtask

  task automatic do_req(input string tag,
                        input logic [3:0] cx, input logic [3:0] cy,
                        input logic [3:0] ax, input logic [3:0] ay,
                        input int elat,
                        input logic [3:0] gx, input logic [3:0] gy,
                        input logic ep, input int ewe,
                        input int estep, input bit glitch);
    int lat;
    int we;
    bit got;
    logic [3:0] ox, oy;
    logic op;
    lat = -1; we = 0; got = 0;
    ox = '0; oy = '0; op = 1'b0;
    @(negedge clk);
    cur_x = cx; cur_y = cy;
    ask_x = ax; ask_y = ay;
    ask_move = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 0) begin
        ask_x = ax + 4'd2;
        ask_y = ay + 4'd1;
      end
      we += int'(map_we);
      if (accept_move) begin
        got = 1; lat = i;
        ox = goto_x; oy = goto_y; op = push_done;
      end
    end
    chk({tag, " accept"}, 32'(got), 1);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " goto_x"}, 32'(ox), 32'(gx));
    chk({tag, " goto_y"}, 32'(oy), 32'(gy));
    chk({tag, " push_done"}, 32'(op), 32'(ep));
    chk({tag, " writes"}, 32'(we), 32'(ewe));
    chk({tag, " step_cnt"}, 32'(step_cnt), 32'(estep));
    @(negedge clk);
    ask_move = 1'b0;
    ask_x = ax; ask_y = ay;
    @(posedge clk); #1;
    chk({tag, " pulse end"},
        32'({accept_move, push_done, map_we}), 0);
    @(negedge clk);
  endtask

  initial begin
    int acc_n;
    int guard;
    for (int i = 0; i < 256; i++) mem[i] = 3'd0;
    #12;
    chk("rst accept", 32'(accept_move), 0);
    chk("rst we", 32'(map_we), 0);
    chk("rst push", 32'(push_done), 0);
    chk("rst step", 32'(step_cnt), 0);
    chk("rst addr", 32'(map_addr), 0);
    @(negedge clk);
    rstn = 1'b1;

    set_tile(7, 11, 0);
    do_req("floor", 6, 11, 7, 11, 2, 7, 11, 0, 0, 1, 0);
    set_tile(7, 11, 1);
    do_req("wall", 6, 11, 7, 11, 2, 6, 11, 0, 0, 1, 0);
    set_tile(7, 11, 6);
    do_req("code6", 6, 11, 7, 11, 2, 6, 11, 0, 0, 1, 0);
    set_tile(7, 11, 2);
    do_req("goal", 6, 11, 7, 11, 2, 7, 11, 0, 0, 2, 0);

    set_tile(7, 11, 3); set_tile(8, 11, 2);
    do_req("push", 6, 11, 7, 11, 5, 7, 11, 1, 2, 3, 0);
    chk("push beyond", 32'(mem[{4'd11, 4'd8}]), 4);
    chk("push target", 32'(mem[{4'd11, 4'd7}]), 0);

    set_tile(7, 11, 3); set_tile(8, 11, 3);
    do_req("blocked", 6, 11, 7, 11, 4, 6, 11, 0, 0, 3, 0);
    chk("blocked beyond", 32'(mem[{4'd11, 4'd8}]), 3);

    do_req("wrap", 15, 3, 0, 3, 0, 15, 3, 0, 0, 3, 0);
    do_req("diag", 3, 3, 4, 4, 0, 3, 3, 0, 0, 3, 0);

    set_tile(7, 11, 4); set_tile(8, 11, 0);
    do_req("push bog", 6, 11, 7, 11, 5, 7, 11, 1, 2, 4, 0);
    chk("bog beyond", 32'(mem[{4'd11, 4'd8}]), 3);
    chk("bog target", 32'(mem[{4'd11, 4'd7}]), 2);

    set_tile(15, 5, 3);
    do_req("edge x", 14, 5, 15, 5, 2, 14, 5, 0, 0, 4, 0);
    set_tile(2, 0, 0);
    do_req("up", 2, 1, 2, 0, 2, 2, 0, 0, 0, 5, 0);
    set_tile(2, 0, 3);
    do_req("edge y", 2, 1, 2, 0, 2, 2, 1, 0, 0, 5, 0);

    set_tile(7, 11, 0);
    do_req("glitch", 6, 11, 7, 11, 2, 7, 11, 0, 0, 6, 1);

    // request held after accept must not be resolved again
    acc_n = 0;
    @(negedge clk);
    cur_x = 6; cur_y = 11; ask_x = 7; ask_y = 11;
    ask_move = 1'b1;
    guard = 0;
    while (!accept_move && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (accept_move) acc_n++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (accept_move) acc_n++;
    end
    chk("hold accepts", 32'(acc_n), 1);
    chk("hold step", 32'(step_cnt), 7);
    @(negedge clk); ask_move = 1'b0;
    @(negedge clk); @(negedge clk);

    set_tile(1, 0, 0);
    for (int k = 0; k < 1030; k++) begin
      @(negedge clk);
      cur_x = 0; cur_y = 0; ask_x = 1; ask_y = 0;
      ask_move = 1'b1;
      guard = 0;
      while (!accept_move && guard < 20) begin
        @(posedge clk); #1; guard++;
      end
      @(negedge clk); ask_move = 1'b0;
      @(negedge clk);
    end
    chk("step saturate", 32'(step_cnt), 1023);

    set_tile(7, 11, 3); set_tile(8, 11, 0);
    @(negedge clk);
    cur_x = 6; cur_y = 11; ask_x = 7; ask_y = 11;
    ask_move = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst addr", 32'(map_addr), 32'({4'd11, 4'd8}));
    rstn = 1'b0;
    #1;
    chk("rst2 accept", 32'(accept_move), 0);
    chk("rst2 we", 32'(map_we), 0);
    chk("rst2 wdata", 32'(map_wdata), 0);
    chk("rst2 push", 32'(push_done), 0);
    chk("rst2 step", 32'(step_cnt), 0);
    chk("rst2 addr", 32'(map_addr), 0);
    chk("rst2 goto", 32'({goto_y, goto_x}), 0);
    ask_move = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst2 mem", 32'(mem[{4'd11, 4'd8}]), 0);
    set_tile(7, 11, 0);
    do_req("after rst", 6, 11, 7, 11, 2, 7, 11, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
